imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 or 64.
REQ-002 SHALL have parameter CNT_W, default 16, width of the illegal-format counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port In  input  32  instruction word.
REQ-006 SHALL have port ImmSrc  input  3  immediate format select.
REQ-007 SHALL have port in_valid  input  1  In/ImmSrc valid.
REQ-008 SHALL have port in_ready  output  1  block can accept.
REQ-009 SHALL have port flush  input  1  discard all buffered entries.
REQ-010 SHALL have port Imm_Ext  output  XLEN  extended immediate.
REQ-011 SHALL have port out_valid  output  1  Imm_Ext valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts.
REQ-013 SHALL have port illegal  output  1  head entry had ImmSrc=111.
REQ-014 SHALL have port err_cnt  output  CNT_W  count of accepted illegal entries.

Function
REQ-015 Decode SHALL be: 000 I {sext In[31:20]}; 001 S {sext In[31:25],In[11:7]}; 010 B {sext In[31],In[7],In[30:25],In[11:8],0}; 011 U {sext In[31:12],12'b0}; 100 J {sext In[31],In[19:12],In[20],In[30:21],0}.
REQ-016 Decode SHALL be: 101 shamt, zero-extended In[24:20] (XLEN=32) or In[25:20] (XLEN=64); 110 CSR zimm, zero-extended In[19:15]; 111 Imm_Ext=0 with illegal=1.
REQ-017 Sign extension SHALL replicate In[31] up to XLEN bits, including bits 63:32 for U-type when XLEN=64.
REQ-018 Transfer SHALL occur on in_valid&in_ready (accept) and on out_valid&out_ready (retire).
REQ-019 Storage SHALL be a 2-entry skid buffer (head, skid); accept-to-out_valid latency SHALL be 1 cycle when empty.
REQ-020 in_ready SHALL be a registered signal, equal to !skid_valid.
REQ-021 An accept while head is valid and not retiring SHALL write the skid entry.
REQ-022 A retire while skid is valid SHALL move skid to head in the same edge, preserving order.
REQ-023 Simultaneous accept and retire with skid empty SHALL load head with the new entry; out_valid SHALL stay 1.
REQ-024 flush SHALL clear head and skid valid on the next edge, drop any same-cycle accept, and force in_ready=1; err_cnt SHALL NOT change from entries dropped by flush.
REQ-025 Imm_Ext and illegal SHALL be held stable while out_valid=1 and out_ready=0.
REQ-026 err_cnt SHALL increment by 1 on each accepted ImmSrc=111 and saturate at all-ones.

Reset
REQ-027 While rst=0 at an edge: head/skid valid=0, Imm_Ext=0, illegal=0, err_cnt=0, and in_ready=0.
REQ-028 in_ready SHALL become 1 on the first edge with rst=1.
REQ-029 Reset mid-transfer SHALL discard all entries; no output SHALL appear after reset release without a new accept.

Verification
REQ-030 Single I-type: In=32'hFFF00093, ImmSrc=000, out_ready=1 -> next cycle out_valid=1, Imm_Ext=32'hFFFFFFFF.
REQ-031 Format sweep: B In=32'hFE000EE3 -> 32'hFFFFFFFC; U In=32'h123450B7 -> 32'h12345000; 110 In=32'h000F9073 -> 32'h0000001F. XLEN=64: U case -> 64'h0000000012345000.
REQ-032 Backpressure: out_ready=0, three back-to-back inputs -> first two accepted, in_ready=0 on the third; then out_ready=1 -> outputs retire in order, one per cycle, and in_ready returns to 1.
REQ-033 Flush: two entries buffered, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, err_cnt unchanged.
REQ-034 Illegal: 3 accepts with ImmSrc=111 -> illegal=1 with Imm_Ext=0 each, err_cnt=3; CNT_W=2 with 5 accepts -> err_cnt=3 (saturated).
REQ-035 Reset mid-operation: rst=0 with skid full -> out_valid=0, err_cnt=0, in_ready=0; after release, in_ready=1 and no spurious output.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator behind a 2-entry skid buffer (head, skid).
// Counts accepted illegal-format entries in a saturating counter.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      In,
  input  logic [2:0]       ImmSrc,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [XLEN-1:0]  Imm_Ext,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             illegal,
  output logic [CNT_W-1:0] err_cnt
);

  logic [31:0]      imm32;
  logic             sext;
  logic             dec_ill;
  logic [63:0]      imm_wide;
  logic [XLEN-1:0]  dec_imm;

  logic             head_valid, skid_valid;
  logic [XLEN-1:0]  head_imm, skid_imm;
  logic             head_ill, skid_ill;
  logic             rdy_q;
  logic [CNT_W-1:0] err_q;

  logic             accept, retire;
  logic             head_valid_d, skid_valid_d;
  logic             load_head_new, load_head_skid, load_skid_new;

  always_comb begin
    imm32   = '0;
    sext    = 1'b0;
    dec_ill = 1'b0;
    case (ImmSrc)
      3'b000: begin imm32 = {{20{In[31]}}, In[31:20]}; sext = 1'b1; end
      3'b001: begin imm32 = {{20{In[31]}}, In[31:25], In[11:7]}; sext = 1'b1; end
      3'b010: begin imm32 = {{19{In[31]}}, In[31], In[7], In[30:25], In[11:8], 1'b0}; sext = 1'b1; end
      3'b011: begin imm32 = {In[31:12], 12'b0}; sext = 1'b1; end
      3'b100: begin imm32 = {{11{In[31]}}, In[31], In[19:12], In[20], In[30:21], 1'b0}; sext = 1'b1; end
      // Shift amount gains a sixth bit only on a 64-bit datapath.
      3'b101: imm32 = {26'b0, (XLEN == 64) ? In[25] : 1'b0, In[24:20]};
      3'b110: imm32 = {27'b0, In[19:15]};
      default: dec_ill = 1'b1;
    endcase
    imm_wide = {{32{sext & imm32[31]}}, imm32};
    dec_imm  = imm_wide[XLEN-1:0];
  end

  // in_ready is the registered complement of the next skid occupancy, so an
  // accept can never arrive while the skid entry is held.
  assign accept = in_valid & rdy_q;
  assign retire = head_valid & out_ready;

  always_comb begin
    head_valid_d   = head_valid;
    skid_valid_d   = skid_valid;
    load_head_new  = 1'b0;
    load_head_skid = 1'b0;
    load_skid_new  = 1'b0;
    if (retire) begin
      if (skid_valid) begin
        load_head_skid = 1'b1;
        skid_valid_d   = 1'b0;
      end else if (accept) begin
        load_head_new  = 1'b1;
      end else begin
        head_valid_d   = 1'b0;
      end
    end else if (accept) begin
      if (head_valid) begin
        load_skid_new = 1'b1;
        skid_valid_d  = 1'b1;
      end else begin
        load_head_new = 1'b1;
        head_valid_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
      head_imm   <= '0;
      head_ill   <= 1'b0;
      skid_imm   <= '0;
      skid_ill   <= 1'b0;
      rdy_q      <= 1'b0;
      err_q      <= '0;
    end else if (flush) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
      rdy_q      <= 1'b1;
    end else begin
      head_valid <= head_valid_d;
      skid_valid <= skid_valid_d;
      rdy_q      <= ~skid_valid_d;
      if (load_head_skid) begin
        head_imm <= skid_imm;
        head_ill <= skid_ill;
      end else if (load_head_new) begin
        head_imm <= dec_imm;
        head_ill <= dec_ill;
      end
      if (load_skid_new) begin
        skid_imm <= dec_imm;
        skid_ill <= dec_ill;
      end
      if (accept && dec_ill && (err_q != {CNT_W{1'b1}}))
        err_q <= err_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = head_valid;
  assign Imm_Ext   = head_imm;
  assign illegal   = head_ill;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: default DUT, a 64-bit DUT and a 2-bit
// counter DUT share the same stimulus.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] In;
  logic [2:0]  ImmSrc;
  logic        in_valid, flush, out_ready;

  logic        in_ready, out_valid, illegal;
  logic [31:0] Imm_Ext;
  logic [15:0] err_cnt;

  logic        rdy64, ov64, ill64;
  logic [63:0] imm64;
  logic [15:0] err64;

  logic        rdy2, ov2, ill2;
  logic [31:0] imm2;
  logic [1:0]  err2;

  int cmp_cnt  = 0;
  int fail_cnt = 0;
  int exp_err  = 0;
  int exp_err2 = 0;

  always #5 clk = ~clk;

  imm_gen_pipe dut (
    .clk(clk), .rst(rst), .In(In), .ImmSrc(ImmSrc), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .Imm_Ext(Imm_Ext), .out_valid(out_valid),
    .out_ready(out_ready), .illegal(illegal), .err_cnt(err_cnt)
  );

  imm_gen_pipe #(.XLEN(64), .CNT_W(16)) dut64 (
    .clk(clk), .rst(rst), .In(In), .ImmSrc(ImmSrc), .in_valid(in_valid),
    .in_ready(rdy64), .flush(flush), .Imm_Ext(imm64), .out_valid(ov64),
    .out_ready(out_ready), .illegal(ill64), .err_cnt(err64)
  );

  imm_gen_pipe #(.XLEN(32), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .In(In), .ImmSrc(ImmSrc), .in_valid(in_valid),
    .in_ready(rdy2), .flush(flush), .Imm_Ext(imm2), .out_valid(ov2),
    .out_ready(out_ready), .illegal(ill2), .err_cnt(err2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    In = 32'h0; ImmSrc = 3'b000;
    tick(); tick();
    cmp_cnt++; if (in_ready !== 1'b0) begin fail_cnt++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    cmp_cnt++; if (out_valid !== 1'b0) begin fail_cnt++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    cmp_cnt++; if (Imm_Ext !== 32'h0) begin fail_cnt++; $display("FAIL reset_imm: got %h want 0", Imm_Ext); end
    cmp_cnt++; if (illegal !== 1'b0) begin fail_cnt++; $display("FAIL reset_illegal: got %b want 0", illegal); end
    cmp_cnt++; if (err_cnt !== 16'd0) begin fail_cnt++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    rst = 1'b1;
    tick();
    cmp_cnt++; if (in_ready !== 1'b1) begin fail_cnt++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    cmp_cnt++; if (out_valid !== 1'b0) begin fail_cnt++; $display("FAIL release_out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    In = 32'hFFFF_FFFF; ImmSrc = 3'b111; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_err++;
      exp_err2 = (exp_err2 < 3) ? exp_err2 + 1 : 3;
      cmp_cnt++; if (out_valid !== 1'b1) begin fail_cnt++; $display("FAIL ill_out_valid[%0d]: got %b want 1", i, out_valid); end
      cmp_cnt++; if (illegal !== 1'b1) begin fail_cnt++; $display("FAIL ill_flag[%0d]: got %b want 1", i, illegal); end
      cmp_cnt++; if (Imm_Ext !== 32'h0) begin fail_cnt++; $display("FAIL ill_imm[%0d]: got %h want 0", i, Imm_Ext); end
      cmp_cnt++; if (err_cnt !== 16'(exp_err)) begin fail_cnt++; $display("FAIL ill_err_cnt[%0d]: got %0d want %0d", i, err_cnt, exp_err); end
      cmp_cnt++; if (err2 !== 2'(exp_err2)) begin fail_cnt++; $display("FAIL ill_err_sat[%0d]: got %0d want %0d", i, err2, exp_err2); end
    end
    in_valid = 1'b0;
    tick();
    cmp_cnt++; if (out_valid !== 1'b0) begin fail_cnt++; $display("FAIL ill_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    In = 32'hFFF0_0093; ImmSrc = 3'b000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cmp_cnt++; if (out_valid !== 1'b1) begin fail_cnt++; $display("FAIL single_out_valid: got %b want 1", out_valid); end
    cmp_cnt++; if (Imm_Ext !== 32'hFFFF_FFFF) begin fail_cnt++; $display("FAIL single_imm: got %h want ffffffff", Imm_Ext); end
    cmp_cnt++; if (illegal !== 1'b0) begin fail_cnt++; $display("FAIL single_illegal: got %b want 0", illegal); end
    tick();
    cmp_cnt++; if (out_valid !== 1'b0) begin fail_cnt++; $display("FAIL single_retire: got %b want 0", out_valid); end
  endtask

  task automatic test_formats();
    logic [31:0] v_in  [8];
    logic [2:0]  v_src [8];
    logic [31:0] v_e32 [8];
    logic [63:0] v_e64 [8];
    v_in[0] = 32'h7FF0_0093; v_src[0] = 3'b000; v_e32[0] = 32'h0000_07FF; v_e64[0] = 64'h0000_0000_0000_07FF;
    v_in[1] = 32'hFE11_2E23; v_src[1] = 3'b001; v_e32[1] = 32'hFFFF_FFFC; v_e64[1] = 64'hFFFF_FFFF_FFFF_FFFC;
    v_in[2] = 32'hFE00_0EE3; v_src[2] = 3'b010; v_e32[2] = 32'hFFFF_FFFC; v_e64[2] = 64'hFFFF_FFFF_FFFF_FFFC;
    v_in[3] = 32'h1234_50B7; v_src[3] = 3'b011; v_e32[3] = 32'h1234_5000; v_e64[3] = 64'h0000_0000_1234_5000;
    v_in[4] = 32'hFF9F_F06F; v_src[4] = 3'b100; v_e32[4] = 32'hFFFF_FFF8; v_e64[4] = 64'hFFFF_FFFF_FFFF_FFF8;
    v_in[5] = 32'h03F0_0013; v_src[5] = 3'b101; v_e32[5] = 32'h0000_001F; v_e64[5] = 64'h0000_0000_0000_003F;
    v_in[6] = 32'h000F_9073; v_src[6] = 3'b110; v_e32[6] = 32'h0000_001F; v_e64[6] = 64'h0000_0000_0000_001F;
    v_in[7] = 32'h8000_00B7; v_src[7] = 3'b011; v_e32[7] = 32'h8000_0000; v_e64[7] = 64'hFFFF_FFFF_8000_0000;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      In = v_in[i]; ImmSrc = v_src[i];
      tick();
      cmp_cnt++; if (out_valid !== 1'b1) begin fail_cnt++; $display("FAIL fmt_valid[%0d]: got %b want 1", i, out_valid); end
      cmp_cnt++; if (Imm_Ext !== v_e32[i]) begin fail_cnt++; $display("FAIL fmt_imm32[%0d]: got %h want %h", i, Imm_Ext, v_e32[i]); end
      cmp_cnt++; if (imm64 !== v_e64[i]) begin fail_cnt++; $display("FAIL fmt_imm64[%0d]: got %h want %h", i, imm64, v_e64[i]); end
      cmp_cnt++; if (illegal !== 1'b0) begin fail_cnt++; $display("FAIL fmt_illegal[%0d]: got %b want 0", i, illegal); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    In = 32'hFFF0_0093; ImmSrc = 3'b000; in_valid = 1'b1;
    tick();
    cmp_cnt++; if (in_ready !== 1'b1) begin fail_cnt++; $display("FAIL bp_ready_after_1: got %b want 1", in_ready); end
    In = 32'h1234_50B7; ImmSrc = 3'b011;
    tick();
    In = 32'h000F_9073; ImmSrc = 3'b110;
    cmp_cnt++; if (in_ready !== 1'b0) begin fail_cnt++; $display("FAIL bp_ready_full: got %b want 0", in_ready); end
    tick();
    cmp_cnt++; if (in_ready !== 1'b0) begin fail_cnt++; $display("FAIL bp_ready_hold: got %b want 0", in_ready); end
    cmp_cnt++; if (Imm_Ext !== 32'hFFFF_FFFF) begin fail_cnt++; $display("FAIL bp_hold_imm: got %h want ffffffff", Imm_Ext); end
    cmp_cnt++; if (out_valid !== 1'b1) begin fail_cnt++; $display("FAIL bp_hold_valid: got %b want 1", out_valid); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    cmp_cnt++; if (Imm_Ext !== 32'h1234_5000) begin fail_cnt++; $display("FAIL bp_second: got %h want 12345000", Imm_Ext); end
    cmp_cnt++; if (out_valid !== 1'b1) begin fail_cnt++; $display("FAIL bp_second_valid: got %b want 1", out_valid); end
    cmp_cnt++; if (in_ready !== 1'b1) begin fail_cnt++; $display("FAIL bp_ready_back: got %b want 1", in_ready); end
    tick();
    cmp_cnt++; if (out_valid !== 1'b0) begin fail_cnt++; $display("FAIL bp_drained: got %b want 0 (third must not be accepted)", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    In = 32'h7FF0_0093; ImmSrc = 3'b000; in_valid = 1'b1;
    tick();
    ImmSrc = 3'b111;
    tick();
    exp_err++;
    exp_err2 = (exp_err2 < 3) ? exp_err2 + 1 : 3;
    cmp_cnt++; if (err_cnt !== 16'(exp_err)) begin fail_cnt++; $display("FAIL flush_pre_err: got %0d want %0d", err_cnt, exp_err); end
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    cmp_cnt++; if (out_valid !== 1'b0) begin fail_cnt++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    cmp_cnt++; if (in_ready !== 1'b1) begin fail_cnt++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    cmp_cnt++; if (err_cnt !== 16'(exp_err)) begin fail_cnt++; $display("FAIL flush_err: got %0d want %0d", err_cnt, exp_err); end
    In = 32'h7FF0_0093; ImmSrc = 3'b000; in_valid = 1'b1;
    tick();
    ImmSrc = 3'b111; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cmp_cnt++; if (out_valid !== 1'b0) begin fail_cnt++; $display("FAIL flush2_out_valid: got %b want 0", out_valid); end
    cmp_cnt++; if (err_cnt !== 16'(exp_err)) begin fail_cnt++; $display("FAIL flush2_err_drop: got %0d want %0d", err_cnt, exp_err); end
    tick();
    cmp_cnt++; if (out_valid !== 1'b0) begin fail_cnt++; $display("FAIL flush2_no_ghost: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    In = 32'hFFF0_0093; ImmSrc = 3'b000; in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    cmp_cnt++; if (in_ready !== 1'b0) begin fail_cnt++; $display("FAIL rmid_full: got %b want 0", in_ready); end
    rst = 1'b0;
    tick();
    cmp_cnt++; if (out_valid !== 1'b0) begin fail_cnt++; $display("FAIL rmid_out_valid: got %b want 0", out_valid); end
    cmp_cnt++; if (err_cnt !== 16'd0) begin fail_cnt++; $display("FAIL rmid_err: got %0d want 0", err_cnt); end
    cmp_cnt++; if (err2 !== 2'd0) begin fail_cnt++; $display("FAIL rmid_err2: got %0d want 0", err2); end
    cmp_cnt++; if (in_ready !== 1'b0) begin fail_cnt++; $display("FAIL rmid_in_ready: got %b want 0", in_ready); end
    cmp_cnt++; if (Imm_Ext !== 32'h0) begin fail_cnt++; $display("FAIL rmid_imm: got %h want 0", Imm_Ext); end
    rst = 1'b1; out_ready = 1'b1;
    tick();
    cmp_cnt++; if (in_ready !== 1'b1) begin fail_cnt++; $display("FAIL rmid_release_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      cmp_cnt++; if (out_valid !== 1'b0) begin fail_cnt++; $display("FAIL rmid_spurious[%0d]: got %b want 0", i, out_valid); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_illegal();
    test_single();
    test_formats();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
